sm_step_ctrl: RTL and testbench

SM_STEP_CTRL -- requirements
Module: sm_step_ctrl

---
 rtl/sm_step_ctrl_if.sv | 24 ++
 rtl/sm_step_ctrl.sv | 145 ++++++++++++++
 tb/tb_sm_step_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sm_step_ctrl_if.sv
// Signal bundle between the step controller, the front-panel keys/switches
// and the debug/clocking side of the CPU core.
interface sm_step_ctrl_if;
  logic        key_mode_n;
  logic        key_step_n;
  logic [3:0]  sw;
  logic        cpu_clk;
  logic [31:0] regData;
  logic        clkEnable;
  logic [3:0]  clkDevide;
  logic [4:0]  regAddr;
  logic [6:0]  led_data;
  logic [1:0]  mode;

  modport slave (
    input  key_mode_n, key_step_n, sw, cpu_clk, regData,
    output clkEnable, clkDevide, regAddr, led_data, mode
  );

  modport master (
    output key_mode_n, key_step_n, sw, cpu_clk, regData,
    input  clkEnable, clkDevide, regAddr, led_data, mode
  );
endinterface

// File: rtl/sm_step_ctrl.sv
// Run/halt/single-step controller for a soft CPU: debounced front-panel keys
// gate the core clock enable and a register-file debug port feeds the LEDs.
module sm_step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic [3:0]  CLK_DIV         = 4'b1000
) (
  input  logic         clk,
  input  logic         rst_n,
  sm_step_ctrl_if.slave bus
);

  localparam logic [1:0] ST_HALT = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_STEP = 2'b10;

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam int KEY_MODE = 0;
  localparam int KEY_STEP = 1;

  // Synchroniser stages; keys idle high, so their flops reset to 1.
  logic [1:0] r_key_s1, r_key_s2;
  logic [3:0] r_sw_s1, r_sw_s2;
  logic       r_cpu_s1, r_cpu_s2, r_cpu_s3;

  logic [CNT_W-1:0] r_db_cnt [2];
  logic [1:0]       r_key_lvl;
  logic [1:0]       r_key_press;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_clk_en;
  logic [4:0] r_reg_addr;
  logic [6:0] r_led;

  logic w_mode_press;
  logic w_step_press;
  logic w_cpu_rise;
  logic w_unused_regdata;

  // NOTE: every flop below uses non-blocking assignment so all registers
  // sample pre-edge values and the pipeline stages cannot collapse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_s1 <= 2'b11;
      r_key_s2 <= 2'b11;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_cpu_s1 <= 1'b0;
      r_cpu_s2 <= 1'b0;
      r_cpu_s3 <= 1'b0;
    end else begin
      r_key_s1 <= {bus.key_step_n, bus.key_mode_n};
      r_key_s2 <= r_key_s1;
      r_sw_s1  <= bus.sw;
      r_sw_s2  <= r_sw_s1;
      r_cpu_s1 <= bus.cpu_clk;
      r_cpu_s2 <= r_cpu_s1;
      r_cpu_s3 <= r_cpu_s2;
    end
  end

  // A key level is accepted only after a full run of differing samples; any
  // agreeing sample restarts the run, which filters contact bounce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        r_db_cnt[k] <= '0;
      end
      r_key_lvl   <= 2'b11;
      r_key_press <= 2'b00;
    end else begin
      for (int k = 0; k < 2; k++) begin
        r_key_press[k] <= 1'b0;
        if (r_key_s2[k] == r_key_lvl[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == CNT_LAST) begin
          r_db_cnt[k]    <= '0;
          r_key_lvl[k]   <= r_key_s2[k];
          r_key_press[k] <= ~r_key_s2[k];
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  assign w_mode_press = r_key_press[KEY_MODE];
  assign w_step_press = r_key_press[KEY_STEP];
  assign w_cpu_rise   = r_cpu_s2 & ~r_cpu_s3;

  // NOTE: the next-state default on entry keeps this block purely
  // combinational on every path, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_HALT: begin
        if (w_mode_press) begin
          w_state_nxt = ST_RUN;
        end else if (w_step_press) begin
          w_state_nxt = ST_STEP;
        end
      end
      ST_RUN: begin
        if (w_mode_press) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_STEP: begin
        if (w_cpu_rise) begin
          w_state_nxt = ST_HALT;
        end
      end
      default: w_state_nxt = ST_HALT;
    endcase
  end

  // clkEnable is decoded from the next state so it flips on the same edge as
  // the state register rather than one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_HALT;
      r_clk_en   <= 1'b0;
      r_reg_addr <= '0;
      r_led      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_clk_en   <= (w_state_nxt != ST_HALT);
      r_reg_addr <= {1'b0, r_sw_s2};
      if (r_state != ST_STEP) begin
        r_led <= bus.regData[6:0];
      end
    end
  end

  assign bus.clkEnable = r_clk_en;
  assign bus.clkDevide = CLK_DIV;
  assign bus.regAddr   = r_reg_addr;
  assign bus.led_data  = r_led;
  assign bus.mode      = r_state;

  assign w_unused_regdata = ^bus.regData[31:7];

endmodule

// File: tb/tb_sm_step_ctrl.sv
// Bench for sm_step_ctrl: sample-history reference model compared every cycle,
// directed key scenarios with literal expectations, then randomized key bounce.
module tb_sm_step_ctrl;

  localparam int N  = 4;
  localparam int HL = N + 2;

  localparam logic [1:0] M_HALT = 2'd0;
  localparam logic [1:0] M_RUN  = 2'd1;
  localparam logic [1:0] M_STEP = 2'd2;

  logic clk = 1'b0;
  logic rst_n;

  sm_step_ctrl_if bus ();

  sm_step_ctrl #(
    .DEBOUNCE_CYCLES(N),
    .CLK_DIV        (4'b1000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw input history per clock edge (bit i = sample i edges
  // ago). Synchronised values are the samples two edges old; a key level flips
  // once the last N synchronised samples all disagree with it.
  logic [HL-1:0] h_mode, h_step;
  logic [3:0]    h_cpu;
  logic [3:0]    h_sw0, h_sw1, h_sw2;
  logic          m_acc_mode, m_acc_step;
  logic          m_pm, m_ps, m_rise;
  logic [1:0]    m_state, m_next;
  logic          m_en;
  logic [4:0]    m_addr;
  logic [6:0]    m_led;

  function automatic logic flips(input logic [N-1:0] win, input logic acc);
    return acc ? (win == {N{1'b0}}) : (win == {N{1'b1}});
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_mode     = '1;
      h_step     = '1;
      h_cpu      = '0;
      h_sw0      = '0;
      h_sw1      = '0;
      h_sw2      = '0;
      m_acc_mode = 1'b1;
      m_acc_step = 1'b1;
      m_pm       = 1'b0;
      m_ps       = 1'b0;
      m_state    = M_HALT;
      m_en       = 1'b0;
      m_addr     = '0;
      m_led      = '0;
    end else begin
      h_mode = {h_mode[HL-2:0], bus.key_mode_n};
      h_step = {h_step[HL-2:0], bus.key_step_n};
      h_cpu  = {h_cpu[2:0], bus.cpu_clk};
      h_sw2  = h_sw1;
      h_sw1  = h_sw0;
      h_sw0  = bus.sw;
      m_rise = h_cpu[2] && !h_cpu[3];

      m_next = m_state;
      if (m_state == M_HALT && m_pm)      m_next = M_RUN;
      else if (m_state == M_HALT && m_ps) m_next = M_STEP;
      else if (m_state == M_RUN && m_pm)  m_next = M_HALT;
      else if (m_state == M_STEP && m_rise) m_next = M_HALT;

      if (m_state != M_STEP) m_led = bus.regData[6:0];
      m_addr  = {1'b0, h_sw2};
      m_state = m_next;
      m_en    = (m_next != M_HALT);

      m_pm = 1'b0;
      if (flips(h_mode[HL-1:2], m_acc_mode)) begin
        m_acc_mode = ~m_acc_mode;
        m_pm       = ~m_acc_mode;
      end
      m_ps = 1'b0;
      if (flips(h_step[HL-1:2], m_acc_step)) begin
        m_acc_step = ~m_acc_step;
        m_ps       = ~m_acc_step;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("mode",      32'(bus.mode),      32'(m_state));
      check("clkEnable", 32'(bus.clkEnable), 32'(m_en));
      check("clkDevide", 32'(bus.clkDevide), 32'h8);
      check("regAddr",   32'(bus.regAddr),   32'(m_addr));
      check("led_data",  32'(bus.led_data),  32'(m_led));
    end
  end

  int   en_rises = 0;
  logic en_prev  = 1'b0;
  always @(negedge clk) begin
    if (bus.clkEnable === 1'b1 && en_prev === 1'b0) en_rises++;
    en_prev = bus.clkEnable;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input bit pm, input bit ps, input int len);
    if (pm) bus.key_mode_n = 1'b0;
    if (ps) bus.key_step_n = 1'b0;
    cyc(len);
    bus.key_mode_n = 1'b1;
    bus.key_step_n = 1'b1;
  endtask

  int len;
  int pm_seg, ps_seg;

  initial begin
    rst_n          = 1'b0;
    bus.key_mode_n = 1'b1;
    bus.key_step_n = 1'b1;
    bus.sw         = 4'h0;
    bus.cpu_clk    = 1'b0;
    bus.regData    = 32'h0;
    #1;
    check("clkdevide_in_reset", 32'(bus.clkDevide), 32'h8);
    cyc(3);
    rst_n = 1'b1;

    cyc(100);
    check("idle_mode", 32'(bus.mode),      32'h0);
    check("idle_en",   32'(bus.clkEnable), 32'h0);

    press(1, 0, 3);
    cyc(10);
    check("short_press_mode", 32'(bus.mode), 32'h0);

    en_rises = 0;
    press(1, 0, 20);
    check("run_mode",   32'(bus.mode),      32'h1);
    check("run_en",     32'(bus.clkEnable), 32'h1);
    check("run_en_one", 32'(en_rises),      32'h1);
    cyc(10);
    press(1, 0, 20);
    check("halt_again_mode", 32'(bus.mode), 32'h0);
    cyc(10);

    bus.regData = 32'h11;
    press(0, 1, 20);
    check("step_mode", 32'(bus.mode),      32'h2);
    check("step_en",   32'(bus.clkEnable), 32'h1);
    bus.regData = 32'h7F;
    cyc(3);
    check("step_led_frozen", 32'(bus.led_data), 32'h11);
    bus.cpu_clk = 1'b1;
    cyc(6);
    check("step_done_mode", 32'(bus.mode),      32'h0);
    check("step_done_en",   32'(bus.clkEnable), 32'h0);
    check("step_done_led",  32'(bus.led_data),  32'h7F);
    bus.cpu_clk = 1'b0;
    cyc(10);

    press(1, 1, 20);
    check("both_keys_mode", 32'(bus.mode), 32'h1);
    cyc(10);
    press(0, 1, 20);
    check("step_in_run_mode", 32'(bus.mode), 32'h1);
    cyc(10);
    press(1, 0, 20);
    cyc(10);
    check("back_to_halt", 32'(bus.mode), 32'h0);

    bus.sw      = 4'hA;
    bus.regData = 32'h0000_0055;
    cyc(3);
    check("regaddr_sw", 32'(bus.regAddr),  32'h0A);
    check("led_55",     32'(bus.led_data), 32'h55);

    for (int seg = 0; seg < 150; seg++) begin
      len    = $urandom_range(1, 14);
      pm_seg = ($urandom_range(0, 2) == 0) ? 1 : 0;
      ps_seg = ($urandom_range(0, 2) == 0) ? 1 : 0;
      bus.key_mode_n = (pm_seg == 0);
      bus.key_step_n = (ps_seg == 0);
      for (int c = 0; c < len; c++) begin
        bus.sw      = 4'($urandom);
        bus.regData = $urandom;
        if ($urandom_range(0, 3) == 0) bus.cpu_clk    = ~bus.cpu_clk;
        if ($urandom_range(0, 9) == 0) bus.key_mode_n = ~bus.key_mode_n;
        if ($urandom_range(0, 9) == 0) bus.key_step_n = ~bus.key_step_n;
        cyc(1);
      end
    end

    bus.key_mode_n = 1'b1;
    bus.key_step_n = 1'b1;
    bus.cpu_clk    = 1'b0;
    rst_n          = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    bus.regData = 32'h2A;
    press(0, 1, 20);
    check("step2_mode", 32'(bus.mode),     32'h2);
    check("step2_led",  32'(bus.led_data), 32'h2A);
    bus.key_step_n = 1'b1;
    rst_n          = 1'b0;
    #1;
    check("rst_step_mode", 32'(bus.mode),      32'h0);
    check("rst_step_en",   32'(bus.clkEnable), 32'h0);
    check("rst_step_led",  32'(bus.led_data),  32'h0);
    cyc(3);
    rst_n = 1'b1;
    cyc(20);
    check("after_rst_mode", 32'(bus.mode), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
